// File: rtl/counter.sv
// counter: saturating down-counter with load and terminal-zero flag.
// Optional feature macro: COUNTER_COUNT_PORT_EN exposes the count register
// on the Count output; without it K is the only output.
module counter #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned LOAD_VALUE = 4
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Load,
`ifdef COUNTER_COUNT_PORT_EN
    output logic [WIDTH-1:0] Count,
`endif
    output logic             K
);

    localparam logic [WIDTH-1:0] LOAD_W = WIDTH'(LOAD_VALUE);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_dec;
    logic             w_zero;

    // Zero decode and saturating decrement of the registered count.
    always_comb begin
        w_zero      = (r_count == '0);
        w_count_dec = w_zero ? r_count : (r_count - WIDTH'(1));
    end

    // Count register: the ternary on Load lets an unknown Load reach count in simulation.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= Load ? LOAD_W : w_count_dec;
        end
    end

    assign K = w_zero;

`ifdef COUNTER_COUNT_PORT_EN
    assign Count = r_count;
`endif

endmodule

// File: tb/tb_counter.sv
// tb_counter: directed scoreboard bench for counter (WIDTH=4, LOAD_VALUE=4).
module tb_counter;

    localparam int unsigned W  = 4;
    localparam int unsigned LV = 4;

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         k;
    } exp_t;

    logic Clk;
    logic Rst_n;
    logic Load;
    logic K;
`ifdef COUNTER_COUNT_PORT_EN
    logic [W-1:0] count_o;
`endif

    int   total;
    int   bad;
    int   m_count;
    exp_t exp_q[$];

    counter #(.WIDTH(W), .LOAD_VALUE(LV)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .Load  (Load),
`ifdef COUNTER_COUNT_PORT_EN
        .Count (count_o),
`endif
        .K     (K)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Compare DUT state against an explicit expected count and flag.
    task automatic check_state(input string tag, input logic [W-1:0] exp_cnt, input logic exp_k);
        check({tag, ".count"}, dut.r_count, exp_cnt);
        check({tag, ".K"}, {3'b000, K}, {3'b000, exp_k});
`ifdef COUNTER_COUNT_PORT_EN
        check({tag, ".Count"}, count_o, exp_cnt);
`endif
    endtask

    // One clock step: drive Load at negedge, push model prediction, compare after posedge.
    task automatic cyc(input string tag, input logic ld);
        exp_t e;
        exp_t got;
        @(negedge Clk);
        Rst_n = 1'b1;
        Load  = ld;
        if (ld)               m_count = LV;
        else if (m_count > 0) m_count = m_count - 1;
        e.cnt = W'(m_count);
        e.k   = (m_count == 0);
        exp_q.push_back(e);
        @(posedge Clk);
        #1;
        total++;
        assert (exp_q.size() != 0) else begin
            bad++;
            $error("FAIL %s.queue observed=empty expected=entry", tag);
        end
        if (exp_q.size() != 0) begin
            got = exp_q.pop_front();
            check_state(tag, got.cnt, got.k);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        m_count = 0;
        Rst_n   = 1'b0;
        Load    = 1'b0;

        // Reset held with clock running.
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk);
            #1;
            check_state("reset", 4'd0, 1'b1);
        end

        // Release with Load low: stays at zero.
        for (int i = 0; i < 5; i++) cyc("idle", 1'b0);

        // Single load and countdown, with literal expectations as well.
        cyc("load1", 1'b1);
        check_state("load1_lit", 4'd4, 1'b0);
        cyc("dec3", 1'b0);
        check_state("dec3_lit", 4'd3, 1'b0);
        cyc("dec2", 1'b0);
        cyc("dec1", 1'b0);
        check_state("dec1_lit", 4'd1, 1'b0);
        cyc("dec0", 1'b0);
        check_state("dec0_lit", 4'd0, 1'b1);
        cyc("hold0a", 1'b0);
        cyc("hold0b", 1'b0);
        check_state("sat_lit", 4'd0, 1'b1);

        // Back-to-back reload right after K rises.
        cyc("b2b_load", 1'b1);
        for (int i = 0; i < 4; i++) cyc("b2b_dec", 1'b0);
        check_state("b2b_end_lit", 4'd0, 1'b1);

        // Mid-count reload at count=2.
        cyc("mid_load", 1'b1);
        cyc("mid_dec3", 1'b0);
        cyc("mid_dec2", 1'b0);
        cyc("mid_reload", 1'b1);
        check_state("mid_reload_lit", 4'd4, 1'b0);
        for (int i = 0; i < 3; i++) cyc("mid_dec", 1'b0);
        check_state("mid_k_low_lit", 4'd1, 1'b0);
        cyc("mid_last", 1'b0);
        check_state("mid_k_high_lit", 4'd0, 1'b1);

        // Long load held three edges.
        for (int i = 0; i < 3; i++) cyc("long_load", 1'b1);
        check_state("long_hold_lit", 4'd4, 1'b0);
        for (int i = 0; i < 4; i++) cyc("long_dec", 1'b0);

        // Async reset mid-count at count=3, between edges.
        cyc("ar_load", 1'b1);
        cyc("ar_dec3", 1'b0);
        @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        check_state("async_rst", 4'd0, 1'b1);
        m_count = 0;
        #2;
        Rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc("after_rst", 1'b0);

        // Reset released while Load is high: loads at first edge after release.
        @(negedge Clk);
        Rst_n = 1'b0;
        Load  = 1'b1;
        m_count = 0;
        @(posedge Clk);
        #1;
        check_state("rst_with_load", 4'd0, 1'b1);
        cyc("rel_load", 1'b1);
        check_state("rel_load_lit", 4'd4, 1'b0);
        for (int i = 0; i < 5; i++) cyc("rel_dec", 1'b0);
        check_state("final_lit", 4'd0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
